// File: rtl/multiple_sum_if.sv
// Handshake bundle for multiple_sum: one array in, one sum out.
// The master side is the producer/consumer, the slave side is the adder.
interface multiple_sum_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_INPUTS = 8
);
    localparam int SUM_WIDTH = DATA_WIDTH + $clog2(NUM_INPUTS);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in [NUM_INPUTS];
    logic                  out_valid;
    logic                  out_ready;
    logic [SUM_WIDTH-1:0]  out;

    modport master (
        output in_valid, in, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, in, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/multiple_sum.sv
// Serial array adder: captures NUM_INPUTS elements, sums them one per
// cycle through a single adder, then holds the result until taken.
module multiple_sum #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_INPUTS = 8
) (
    input logic          clk,
    input logic          rst,
    multiple_sum_if.slave bus
);
    localparam int SUM_WIDTH = DATA_WIDTH + $clog2(NUM_INPUTS);
    localparam int IDX_W     = $clog2(NUM_INPUTS);
    localparam int PAD       = SUM_WIDTH - DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] buffer [NUM_INPUTS];
    logic [SUM_WIDTH-1:0]  acc;
    logic [SUM_WIDTH-1:0]  acc_sum;
    logic [SUM_WIDTH-1:0]  out_r;
    logic [IDX_W-1:0]      idx;
    logic                  accept;
    logic                  last;

    assign accept  = bus.in_valid && (state == IDLE);
    assign last    = (idx == IDX_W'(NUM_INPUTS - 1));
    assign acc_sum = acc + {{PAD{1'b0}}, buffer[idx]};

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out       = out_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.in_valid) state_nxt = ACCUM;
            ACCUM:   if (last) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // out_r is only written on the final add, so it stays put through DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                buffer[i] <= '0;
            end
            acc   <= '0;
            idx   <= '0;
            out_r <= '0;
        end else if (accept) begin
            buffer <= bus.in;
            acc    <= '0;
            idx    <= '0;
        end else if (state == ACCUM) begin
            acc <= acc_sum;
            idx <= idx + IDX_W'(1);
            if (last) begin
                out_r <= acc_sum;
            end
        end
    end
endmodule

// File: tb/tb_multiple_sum.sv
// Randomized bench for multiple_sum against a plain-arithmetic sum model.
// Covers latency, backpressure, input isolation, streaming and reset.
module tb_multiple_sum;
    localparam int DW = 16;
    localparam int N  = 8;
    localparam int SW = DW + $clog2(N);

    typedef logic [DW-1:0] arr_t [N];

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    multiple_sum_if #(.DATA_WIDTH(DW), .NUM_INPUTS(N)) bus ();

    multiple_sum #(.DATA_WIDTH(DW), .NUM_INPUTS(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint ref_sum(input arr_t a);
        longint s = 0;
        for (int i = 0; i < N; i++) s += longint'(a[i]);
        return s;
    endfunction

    function automatic arr_t rand_arr();
        arr_t r;
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(3))
                0:       r[i] = '0;
                1:       r[i] = '1;
                default: r[i] = DW'($urandom);
            endcase
        end
        return r;
    endfunction

    task automatic scramble(input bit iso);
        for (int i = 0; i < N; i++)
            bus.in[i] = iso ? DW'(16'h1234) : DW'($urandom);
    endtask

    // One transaction; bp = cycles of out_ready=0 after out_valid rises
    task automatic run_one(input arr_t a, input int bp, input bit iso);
        logic [SW-1:0] held;
        int cyc;
        @(negedge clk);
        bus.in        = a;
        bus.in_valid  = 1'b1;
        bus.out_ready = (bp == 0);
        cyc = 0;
        while (!bus.in_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.in_ready) begin
            check("accept_timeout", 0, 1);
            return;
        end
        @(posedge clk);
        cyc = 0;
        do begin
            @(negedge clk);
            scramble(iso);
            @(posedge clk);
            #1;
            cyc++;
        end while (!bus.out_valid && cyc < 50);
        check("latency", cyc, N);
        check("sum", bus.out, ref_sum(a));
        held = bus.out;
        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            scramble(1'b0);
            @(posedge clk);
            #1;
            check("bp_valid", bus.out_valid, 1);
            check("bp_stable", bus.out, held);
            check("bp_in_ready", bus.in_ready, 0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        @(posedge clk);
        #1;
        check("valid_drop", bus.out_valid, 0);
        check("out_hold", bus.out, held);
        check("ready_back", bus.in_ready, 1);
    endtask

    task automatic watch_quiet(input string tag, input int cycles);
        int seen = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        check(tag, seen, 0);
    endtask

    task automatic accept_one(input arr_t a);
        @(negedge clk);
        bus.in       = a;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        arr_t a;
        arr_t sq [4];
        longint exp_q [$];
        int drv, got, last_t;
        bit prev;

        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < N; i++) bus.in[i] = DW'(i + 3);
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out", bus.out, 0);
        check("rst_in_ready", bus.in_ready, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("rel_in_ready", bus.in_ready, 1);
        check("rel_out_valid", bus.out_valid, 0);

        for (int i = 0; i < N; i++) a[i] = DW'(i);
        run_one(a, 0, 1'b0);
        for (int i = 0; i < N; i++) a[i] = '1;
        run_one(a, 0, 1'b0);
        check("max_sum", bus.out, 19'h7FFF8);
        for (int i = 0; i < N; i++) a[i] = DW'(10);
        run_one(a, 0, 1'b1);
        run_one(rand_arr(), 5, 1'b0);
        for (int t = 0; t < 6; t++)
            run_one(rand_arr(), $urandom_range(3), $urandom_range(1) == 1);

        for (int k = 0; k < 4; k++) sq[k] = rand_arr();
        drv = 0;
        got = 0;
        last_t = -1;
        prev = 1'b0;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 80 && got < 4; cyc++) begin
            @(negedge clk);
            if (bus.in_ready && drv < 4) begin
                bus.in       = sq[drv];
                bus.in_valid = 1'b1;
                exp_q.push_back(ref_sum(sq[drv]));
                drv++;
            end else if (bus.in_ready) begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (bus.out_valid && !prev) begin
                if (exp_q.size() == 0) check("stream_extra", 1, 0);
                else check("stream_sum", bus.out, exp_q.pop_front());
                if (last_t >= 0) check("stream_gap", cyc - last_t, N + 2);
                last_t = cyc;
                got++;
            end
            prev = bus.out_valid;
        end
        check("stream_count", got, 4);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);

        accept_one(rand_arr());
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_acc_valid", bus.out_valid, 0);
        check("mid_acc_out", bus.out, 0);
        check("mid_acc_ready", bus.in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        watch_quiet("mid_acc_quiet", 12);

        bus.out_ready = 1'b0;
        accept_one(rand_arr());
        repeat (N + 1) @(posedge clk);
        #1;
        check("pre_rst_done", bus.out_valid, 1);
        #1 rst = 1'b1;
        #1;
        check("mid_done_valid", bus.out_valid, 0);
        check("mid_done_out", bus.out, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        watch_quiet("mid_done_quiet", 12);

        run_one(rand_arr(), 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
